// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit with architectural HI/LO registers.
// Optional macro MULDIV_FAST_MUL_EN replaces the shift-add multiply with a one-cycle product.
module muldiv_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             cpu_rst_n,
   input  logic             cpu_en,
   input  logic             start,
   input  logic [1:0]       oper,
   input  logic [WIDTH-1:0] opa,
   input  logic [WIDTH-1:0] opb,
   input  logic             cancel,
   input  logic             hi_wen,
   input  logic             lo_wen,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi_out,
   output logic [WIDTH-1:0] lo_out
);

   typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

   state_t             state, state_next;
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0]   operand;
   logic [CNT_W-1:0]   cnt;
   logic               is_div, neg_res, neg_rem, div_by_zero, div_ovf;
   logic [WIDTH-1:0]   hi_q, lo_q;
   logic               done_q, div_zero_q;

   logic               sign_op, a_neg, b_neg, accept, last;
   logic [WIDTH-1:0]   a_abs, b_abs;
   logic [2*WIDTH-1:0] div_step, prod_fix;
   logic [WIDTH:0]     rem_sh;
   logic [WIDTH+1:0]   diff;
   logic [WIDTH-1:0]   quot_fix, rem_fix;

   assign sign_op = ~oper[0];
   assign a_neg   = sign_op & opa[WIDTH-1];
   assign b_neg   = sign_op & opb[WIDTH-1];
   assign a_abs   = a_neg ? -opa : opa;
   assign b_abs   = b_neg ? -opb : opb;
   assign accept  = (state == IDLE) && start && !cancel;
   assign last    = (cnt == CNT_W'(WIDTH - 1));

`ifdef MULDIV_FAST_MUL_EN
   logic [2*WIDTH-1:0] fast_prod;
   assign fast_prod = {{WIDTH{1'b0}}, operand} * {{WIDTH{1'b0}}, acc[WIDTH-1:0]};
`else
   // Shift-add: conditionally add the multiplicand into the upper half, then shift right.
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_step;
   assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
   assign mul_step = {mul_sum, acc[WIDTH-1:1]};
`endif

   // Restoring divide: upper half is the partial remainder, lower half collects quotient bits.
   assign rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
   assign diff     = {1'b0, rem_sh} - {2'b00, operand};
   assign div_step = diff[WIDTH+1] ? {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                   : {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

   assign prod_fix = neg_res ? -acc : acc;
   assign quot_fix = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
   assign rem_fix  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

   always_ff @(posedge clk or negedge cpu_rst_n) begin
      if (!cpu_rst_n)
         state <= IDLE;
      else if (cpu_en)
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (accept) state_next = oper[1] ? DIV : MUL;
`ifdef MULDIV_FAST_MUL_EN
         MUL:  state_next = FIX;
`else
         MUL:  if (last) state_next = FIX;
`endif
         DIV:  if (last) state_next = FIX;
         FIX:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
      if (cancel && state != IDLE)
         state_next = IDLE;
   end

   always_ff @(posedge clk or negedge cpu_rst_n) begin
      if (!cpu_rst_n) begin
         acc         <= '0;
         operand     <= '0;
         cnt         <= '0;
         is_div      <= 1'b0;
         neg_res     <= 1'b0;
         neg_rem     <= 1'b0;
         div_by_zero <= 1'b0;
         div_ovf     <= 1'b0;
         hi_q        <= '0;
         lo_q        <= '0;
         done_q      <= 1'b0;
         div_zero_q  <= 1'b0;
      end else if (!cpu_en) begin
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (hi_wen) hi_q <= wdata;
         if (lo_wen) lo_q <= wdata;
         case (state)
            IDLE: if (accept) begin
               acc         <= oper[1] ? {{WIDTH{1'b0}}, a_abs} : {{WIDTH{1'b0}}, b_abs};
               operand     <= oper[1] ? b_abs : a_abs;
               cnt         <= '0;
               is_div      <= oper[1];
               neg_res     <= a_neg ^ b_neg;
               neg_rem     <= a_neg;
               div_by_zero <= (opb == '0);
               div_ovf     <= sign_op && (opa == {1'b1, {(WIDTH-1){1'b0}}}) && (opb == '1);
            end
            MUL: begin
`ifdef MULDIV_FAST_MUL_EN
               acc <= fast_prod;
`else
               acc <= mul_step;
`endif
               cnt <= cnt + CNT_W'(1);
            end
            DIV: begin
               acc <= div_step;
               cnt <= cnt + CNT_W'(1);
            end
            FIX: if (!cancel) begin
               done_q <= 1'b1;
               if (is_div) begin
                  hi_q <= rem_fix;
                  lo_q <= div_by_zero ? '1 : quot_fix;
                  if (div_by_zero)
                     div_zero_q <= 1'b1;
                  else if (!div_ovf)
                     div_zero_q <= 1'b0;
               end else begin
                  hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                  lo_q <= prod_fix[WIDTH-1:0];
               end
            end
            default: ;
         endcase
      end
   end

   assign busy     = (state != IDLE);
   assign done     = done_q;
   assign div_zero = div_zero_q;
   assign hi_out   = hi_q;
   assign lo_out   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: random and directed MULT/DIV traffic against an arithmetic model.
// Honours MULDIV_FAST_MUL_EN for the expected multiply latency.
module tb_muldiv_unit;

   localparam int WIDTH = 32;
`ifdef MULDIV_FAST_MUL_EN
   localparam int MUL_LAT = 2;
`else
   localparam int MUL_LAT = WIDTH + 1;
`endif
   localparam int DIV_LAT  = WIDTH + 1;
   localparam int STALL_AT = (MUL_LAT > 4) ? 10 : 1;

   logic             clk, cpu_rst_n, cpu_en, start, cancel, hi_wen, lo_wen;
   logic [1:0]       oper;
   logic [WIDTH-1:0] opa, opb, wdata;
   logic             busy, done, div_zero;
   logic [WIDTH-1:0] hi_out, lo_out;

   muldiv_unit #(.WIDTH(WIDTH), .CNT_W(6)) dut (
      .clk(clk), .cpu_rst_n(cpu_rst_n), .cpu_en(cpu_en), .start(start),
      .oper(oper), .opa(opa), .opb(opb), .cancel(cancel),
      .hi_wen(hi_wen), .lo_wen(lo_wen), .wdata(wdata),
      .busy(busy), .done(done), .div_zero(div_zero),
      .hi_out(hi_out), .lo_out(lo_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed {
      logic [WIDTH-1:0] hi;
      logic [WIDTH-1:0] lo;
      logic             dz;
      int               due;
   } exp_t;

   exp_t             sbq[$];
   int               checks = 0;
   int               failures = 0;
   logic [WIDTH-1:0] model_hi = '0;
   logic [WIDTH-1:0] model_lo = '0;
   logic             model_dz = 1'b0;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // MIPS semantics straight from integer arithmetic: truncating division, remainder follows dividend.
   function automatic void refModel(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                    input logic dz_in, output logic [31:0] hi, output logic [31:0] lo,
                                    output logic dz);
      longint          p;
      longint unsigned pu;
      int              sa, sb;
      sa = a;
      sb = b;
      dz = dz_in;
      hi = '0;
      lo = '0;
      case (op)
         2'd0: begin p = longint'(sa) * longint'(sb); {hi, lo} = p; end
         2'd1: begin pu = {32'b0, a} * {32'b0, b}; {hi, lo} = pu; end
         default: begin
            if (b == 0) begin
               hi = a; lo = '1; dz = 1'b1;
            end else if (op == 2'd2 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
               lo = a; hi = '0;
            end else if (op == 2'd2) begin
               lo = sa / sb; hi = sa % sb; dz = 1'b0;
            end else begin
               lo = a / b; hi = a % b; dz = 1'b0;
            end
         end
      endcase
   endfunction

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (done === 1'b1) begin
            if (sbq.size() == 0) begin
               checks++;
               failures++;
               $display("[TB] FAIL unexpected_done: got done=1 at cycle %0d, expected no done", cyc);
            end else begin
               e = sbq.pop_front();
               checkOutput("hi", hi_out, e.hi);
               checkOutput("lo", lo_out, e.lo);
               checkOutput("div_zero", div_zero, e.dz);
               checkOutput("latency_cycle", cyc, e.due);
               checkOutput("busy_at_done", busy, 0);
            end
         end
      end
   end

   task automatic waitIdle();
      int k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (busy !== 1'b0 && k < 200);
      if (busy !== 1'b0) begin
         checks++;
         failures++;
         $display("[TB] FAIL busy_timeout: got busy=%0b after %0d cycles, expected 0", busy, k);
      end
   endtask

   // mid: 0 none, 1 start pulse while busy, 2 MTHI/MTLO while busy
   task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                input int stall, input int mid);
      exp_t             e;
      logic [WIDTH-1:0] h, l;
      logic             z;
      int               n;
      oper  = op;
      opa   = a;
      opb   = b;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      n     = cyc;
      opa   = $urandom;
      opb   = $urandom;
      refModel(op, a, b, model_dz, h, l, z);
      model_hi = h;
      model_lo = l;
      model_dz = z;
      e.hi  = h;
      e.lo  = l;
      e.dz  = z;
      e.due = n + (op[1] ? DIV_LAT : MUL_LAT) + stall;
      sbq.push_back(e);
      if (stall > 0) begin
         repeat (STALL_AT) @(posedge clk);
         #1 cpu_en = 1'b0;
         repeat (stall) @(posedge clk);
         #1 cpu_en = 1'b1;
      end else if (mid != 0) begin
         @(posedge clk);
         #1;
         wdata = $urandom;
         if (mid == 1) begin
            oper  = 2'($urandom_range(0, 3));
            start = 1'b1;
         end else begin
            hi_wen = 1'b1;
            lo_wen = 1'b1;
         end
         @(posedge clk);
         #1;
         start  = 1'b0;
         hi_wen = 1'b0;
         lo_wen = 1'b0;
      end
      waitIdle();
   endtask

   task automatic writeHiLo(input logic h, input logic l, input logic [31:0] d);
      hi_wen = h;
      lo_wen = l;
      wdata  = d;
      @(posedge clk);
      #1;
      hi_wen = 1'b0;
      lo_wen = 1'b0;
      if (h) model_hi = d;
      if (l) model_lo = d;
      checkOutput("mt_hi", hi_out, model_hi);
      checkOutput("mt_lo", lo_out, model_lo);
   endtask

   function automatic logic [31:0] pickOperand();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      cpu_rst_n = 1'b0;
      cpu_en    = 1'b1;
      start     = 1'b0;
      cancel    = 1'b0;
      hi_wen    = 1'b0;
      lo_wen    = 1'b0;
      oper      = 2'd0;
      opa       = '0;
      opb       = '0;
      wdata     = '0;
      #12;
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_done", done, 0);
      checkOutput("rst_div_zero", div_zero, 0);
      checkOutput("rst_hi", hi_out, 0);
      checkOutput("rst_lo", lo_out, 0);
      cpu_rst_n = 1'b1;
      @(negedge clk);

      applyStimulus(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
      applyStimulus(2'd0, 32'hFFFF_FFF9, 32'd3, 0, 0);
      applyStimulus(2'd2, 32'hFFFF_FFF9, 32'd2, 0, 0);
      applyStimulus(2'd3, 32'd100, 32'd7, 0, 0);
      applyStimulus(2'd3, 32'h1234, 32'd0, 0, 0);
      applyStimulus(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
      applyStimulus(2'd2, 32'd10, 32'd5, 0, 0);
      applyStimulus(2'd2, 32'h8000_0000, 32'd0, 0, 1);
      applyStimulus(2'd0, 32'h8000_0000, 32'h8000_0000, 0, 2);
      applyStimulus(2'd0, 32'h0001_2345, 32'hFFFF_0F0F, 5, 0);

      writeHiLo(1'b0, 1'b1, 32'hA5A5_A5A5);
      writeHiLo(1'b1, 1'b1, 32'h5A5A_0001);

      // Abort a divide mid-flight; HI/LO must keep the MTHI/MTLO values.
      oper  = 2'd2;
      opa   = 32'd1000;
      opb   = 32'd3;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (9) @(posedge clk);
      #1 cancel = 1'b1;
      @(posedge clk);
      #1 cancel = 1'b0;
      checkOutput("cancel_busy", busy, 0);
      checkOutput("cancel_hi", hi_out, model_hi);
      checkOutput("cancel_lo", lo_out, model_lo);
      repeat (40) @(negedge clk);

      start  = 1'b1;
      cancel = 1'b1;
      @(posedge clk);
      #1;
      start  = 1'b0;
      cancel = 1'b0;
      checkOutput("cancel_beats_start", busy, 0);

      for (int i = 0; i < 30; i++)
         applyStimulus(2'($urandom_range(0, 3)), pickOperand(), pickOperand(), 0, 0);

      // Asynchronous reset in the middle of a multiply.
      @(negedge clk);
      oper  = 2'd0;
      opa   = 32'h7;
      opb   = 32'h9;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (4) @(posedge clk);
      #3 cpu_rst_n = 1'b0;
      #1;
      model_hi = '0;
      model_lo = '0;
      model_dz = 1'b0;
      checkOutput("midrst_busy", busy, 0);
      checkOutput("midrst_hi", hi_out, 0);
      checkOutput("midrst_lo", lo_out, 0);
      #3 cpu_rst_n = 1'b1;
      repeat (40) @(negedge clk);

      applyStimulus(2'd2, 32'hFFFF_FFF9, 32'd2, 0, 0);
      repeat (3) @(negedge clk);
      checkOutput("scoreboard_empty", sbq.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised iterative multiply/divide unit holding architectural HI/LO registers for the MIPS CPU.
- Executes MULT, MULTU, DIV and DIVU; handles MTHI and MTLO writes; exposes HI/LO for MFHI and MFLO.
- Sits beside the ALU in the datapath. Control stalls PC/pipeline while `busy` is high.
- Adds multi-cycle operation and a start/busy/done handshake that the single-cycle datapath ALU does not have.

Parameters:
- WIDTH, 32: operand width in bits; HI and LO are each WIDTH bits. Legal values are 8 to 64, even.
- CNT_W, 6: iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  main clock, rising edge.
- cpu_rst_n  input  1  asynchronous active-low reset.
- cpu_en  input  1  global enable; when low, all state is frozen.
- start  input  1  request a new operation; sampled when cpu_en=1.
- oper  input  2  operation select: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU.
- opa  input  WIDTH  rs operand (multiplicand / dividend).
- opb  input  WIDTH  rt operand (multiplier / divisor).
- cancel  input  1  abort the in-flight operation (pipeline flush).
- hi_wen  input  1  MTHI write strobe.
- lo_wen  input  1  MTLO write strobe.
- wdata  input  WIDTH  data for MTHI/MTLO.
- busy  output  1  operation in flight.
- done  output  1  one-cycle pulse when HI/LO are updated by an operation.
- div_zero  output  1  sticky flag: last completed divide had opb=0.
- hi_out  output  WIDTH  current HI.
- lo_out  output  WIDTH  current LO.

Behaviour:
- Reset (asynchronous, cpu_rst_n=0): state IDLE; HI=0, LO=0, busy=0, done=0, div_zero=0, counter=0. Reset mid-operation discards the operation immediately.
- cpu_en=0: no state changes, no strobes taken, and done is held at 0.
- States: IDLE, MUL, DIV, FIX.
- IDLE, start=1:
  - Latch the absolute values of the operands when oper is signed; record the result sign and the remainder sign.
  - Go to MUL (oper=0 or 1) or DIV (oper=2 or 3). busy=1 from the next cycle.
- MUL: shift-add, one bit per cycle, for WIDTH cycles into a 2*WIDTH accumulator. Then go to FIX.
- DIV: restoring division, one quotient bit per cycle, for WIDTH cycles. Then go to FIX.
- FIX (1 cycle):
  - Apply the sign corrections. MULT: negate the product if the operand signs differ. DIV: the quotient sign is the XOR of the operand signs; the remainder takes the dividend's sign.
  - Write HI/LO. MUL: HI = upper product, LO = lower product. DIV: HI = remainder, LO = quotient.
  - Pulse done=1, go to IDLE, busy=0.
- Latency: start accepted at edge N; done=1 and HI/LO valid in the cycle after edge N+WIDTH+1. With WIDTH=32, that is 33 cycles.
- start while busy=1: ignored; no queuing.
- cancel=1 while busy: return to IDLE next edge. HI/LO and div_zero are unchanged and no done is issued. cancel in IDLE has no effect. If cancel and start are both high in IDLE, cancel wins and start is ignored.
- Divide by zero (opb=0):
  - Completes with normal latency.
  - HI = opa (the original, signed value); LO = all ones.
  - div_zero set at FIX. It is cleared by the next completed divide with nonzero opb.
- Signed overflow (DIV with opa=MIN, opb=-1): LO=MIN, HI=0, div_zero unchanged.
- hi_wen/lo_wen:
  - In IDLE: write wdata at the edge; both may be asserted together.
  - While busy: the write takes effect, but the FIX write overwrites it.
  - Same cycle as FIX: the FIX result wins.
- hi_out/lo_out: are direct register outputs with no bypass.

Optional Feature:
- Macro: MULDIV_FAST_MUL_EN.
- Defined: MULT/MULTU skip the MUL iterations. The product is computed combinationally and registered in FIX, so done appears 2 cycles after start. DIV is unaffected.
- Undefined: iterative multiply as described above.

Test Plan:
- MULTU opa=0xFFFFFFFF, opb=0xFFFFFFFF, WIDTH=32 -> done 33 cycles after start; HI=0xFFFFFFFE, LO=0x00000001.
- MULT opa=-7 (0xFFFFFFF9), opb=3 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; with MULDIV_FAST_MUL_EN, done 2 cycles after start.
- DIV opa=-7, opb=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU opa=100, opb=7 -> LO=14, HI=2, div_zero=0.
- DIVU opa=0x1234, opb=0 -> HI=0x1234, LO=0xFFFFFFFF, div_zero=1. A following DIV 10/5 -> LO=2, HI=0, div_zero=0.
- Start DIV, assert cancel at cycle 10 -> busy=0 next cycle, no done, HI/LO keep prior values. Pull cpu_rst_n low mid-MUL -> HI=LO=0 and busy=0 immediately.
- Hold cpu_en=0 for 5 cycles mid-MUL -> done delayed by exactly 5 cycles and the result is correct. MTLO 0xA5A5A5A5 in IDLE -> lo_out=0xA5A5A5A5 next cycle.
